alu_share_ctrl: RTL and testbench
=================================

# alu_share_ctrl

Two-requester controller that shares one combinational 8-bit ALU (4-bit function select, carry in, 8-bit result, 4-bit flag array `{OddParity, Positive, Cout, Zero}`) between two independent clients. It performs round-robin arbitration, registers the granted operation onto the ALU inputs and captures the result and flags. It also keeps a private carry context per requester, so each client can chain multi-byte ADD_ABC/SUB_ABC/rotate sequences without interference. It sits between the instruction-issue logic and the ALU instance.

## Interface
- `CARRY_CTX`, default 1: 1 = per-requester carry fed to `alu_cin`; 0 = `alu_cin` tied 0 and carry registers never update.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1 (N=0,1): operation request.
- `reqN_ready` out 1: accept strobe; transfer when valid & ready at a rising edge.
- `reqN_op` in 4: ALU function code 0x0–0xF.
- `reqN_a` in 8: A operand.
- `reqN_b` in 8: B operand.
- `reqN_carry_clr` in 1: synchronous clear of requester N's carry context.
- `rspN_valid` out 1: one-cycle result pulse.
- `rspN_data` out 8: result, held until the next response to N.
- `rspN_flags` out 4: `{OddParity, Positive, Cout, Zero}`, held until the next response to N.
- `carryN` out 1: current carry context of requester N.
- `busy` out 1: high in EXEC and DONE.
- `alu_s_af` out 4: function select to ALU.
- `alu_a` out 8: A operand to ALU.
- `alu_b` out 8: B operand to ALU.
- `alu_cin` out 1: carry in to ALU.
- `alu_out` in 8: ALU result.
- `alu_flags` in 4: ALU flag array.

## Operation
- FSM states: IDLE → EXEC → DONE → IDLE.
- IDLE:
  - `reqN_ready = (state==IDLE) & grantN`, combinational from valids and the pointer.
  - Grant: if only one request is valid, grant it. If both are valid, grant the one not equal to `last_grant`.
  - On accept, register op/a/b, `owner = N`, and `cin_r = carryN` (0 if `CARRY_CTX=0`).
  - Go to EXEC.
- EXEC:
  - `alu_s_af/alu_a/alu_b/alu_cin` driven from registers.
  - At the closing edge, capture `alu_out`→`rsp[owner]_data` and `alu_flags`→`rsp[owner]_flags`.
  - At the same edge, `carry[owner] <= alu_flags[1]`.
  - Go to DONE.
- DONE: `rsp[owner]_valid = 1` for exactly this cycle; `last_grant <= owner`; go to IDLE.
- ALU drive outside EXEC: `alu_s_af = 0x0`, `alu_a = alu_b = 0`, `alu_cin = 0`.
- ALU contract:
  - SUB_AB/SUB_ABC compute B − A (−Cin) in 9 bits; Cout is bit 8 (borrow).
  - Logical and pass ops give Cout = 0.
  - Rotates (0x6/0x7) move the carry through the context.
  - The controller does not reinterpret results.
- Carry clear:
  - `reqN_carry_clr` clears `carryN` at the next edge in any state.
  - If a clear coincides with a capture for the same N, the clear wins (carry = 0).
  - A clear of the other requester is independent.
- Responses: `rspN_data/flags` are not touched by the other requester's operations.

## Timing
- Reset values:
  - state IDLE, `last_grant = 1` (req0 wins the first tie).
  - All `rsp*_valid/data/flags = 0`, `carry0 = carry1 = 0`, `busy = 0`.
  - ALU drive at idle values; `reqN_ready` follows the IDLE grant logic.
- Latency:
  - Accept edge e0; EXEC cycle between e0 and e1; capture at e1.
  - `rspN_valid` high between e1 and e2.
  - Next accept possible at e3.
  - Throughput: one operation per 3 cycles.
- Valid may drop without acceptance; a request is not retained unless it was accepted.
- Operands are sampled only at the accept edge; later input changes have no effect.
- Async reset in EXEC or DONE aborts the operation:
  - No `rsp*_valid` is produced.
  - Carries and the pointer return to reset values.
  - Accept resumes in the first cycle after deassertion.
- Fairness: with both valid continuously, grants alternate 0,1,0,1; no requester waits more than one operation.

## Test plan
1. **Single req0 ADD_AB.** After reset, req0 ADD_AB (op 0x8) with a=0x05, b=0x03.
   - Required: `req0_ready` in the accept cycle.
   - Required: `alu_s_af = 0x8` in EXEC.
   - Required: `rsp0_valid` 2 cycles after accept, `rsp0_data = 0x08`, `rsp0_flags = 4'b1100`, `carry0 = 0`.
2. **Round-robin.** Both valid continuously from reset with distinct ops.
   - Required: accept order req0, req1, req0, req1, accepts 3 cycles apart.
   - Required: responses on the matching `rspN` only.
3. **Carry chaining.**
   - req1 ADD_AB (op 0x8) a=0xFF, b=0x01 → `rsp1_data = 0x00`, flags `4'b0111`, `carry1 = 1`.
   - Then req1 ADD_ABC (op 0xA) a=0x00, b=0x00 → `rsp1_data = 0x01`, `carry1 = 0`.
   - `carry0` stays 0 throughout.
4. **Borrow.** req0 SUB_AB (op 0x9) a=0x01, b=0x00.
   - Required: `rsp0_data = 0xFF`, `rsp0_flags = 4'b0010`, `carry0 = 1`.
5. **Reset during EXEC.** Assert `rst_n = 0` in the EXEC cycle of an op with `carry0 = 1`.
   - Required: no `rsp0_valid`; `carry0 = 0`; `busy = 0`; ALU drive at idle values.
   - Required: req0 is accepted in the first cycle after release.
6. **Clear vs. update.** Assert `req0_carry_clr` in the EXEC cycle of a req0 op producing Cout = 1.
   - Required: `carry0 = 0` after capture; `rsp0_flags[1] = 1` still reported.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one combinational 8-bit ALU between two
// requesters. Each granted operation is registered onto the ALU inputs for one
// EXEC cycle, its result and flags are captured into the owner's response
// registers, and a per-requester carry context is maintained for chaining.
module alu_share_ctrl #(
  parameter bit CARRY_CTX = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,

  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req0_carry_clr,

  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic       req1_carry_clr,

  output logic       rsp0_valid,
  output logic [7:0] rsp0_data,
  output logic [3:0] rsp0_flags,
  output logic       rsp1_valid,
  output logic [7:0] rsp1_data,
  output logic [3:0] rsp1_flags,

  output logic       carry0,
  output logic       carry1,
  output logic       busy,

  output logic [3:0] alu_s_af,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_cin,
  input  logic [7:0] alu_out,
  input  logic [3:0] alu_flags
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

  // Index of the Cout bit inside the flag array {OddParity, Positive, Cout, Zero}.
  localparam int unsigned CoutBit = 1;

  state_e     r_state;
  state_e     w_state_nxt;

  logic       r_last_grant;
  logic       r_owner;
  logic [3:0] r_op;
  logic [7:0] r_a;
  logic [7:0] r_b;
  logic       r_cin;

  logic [7:0] r_rsp0_data;
  logic [3:0] r_rsp0_flags;
  logic [7:0] r_rsp1_data;
  logic [3:0] r_rsp1_flags;

  logic       r_carry0;
  logic       r_carry1;

  logic       w_idle;
  logic       w_exec;
  logic       w_done;
  logic       w_grant0;
  logic       w_grant1;
  logic       w_acc0;
  logic       w_acc1;
  logic       w_accept;
  logic       w_cap0;
  logic       w_cap1;

  assign w_idle = (r_state == StIdle);
  assign w_exec = (r_state == StExec);
  assign w_done = (r_state == StDone);

  // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant0 = r_last_grant;
      w_grant1 = ~r_last_grant;
    end else begin
      w_grant0 = req0_valid;
      w_grant1 = req1_valid;
    end
  end

  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;

  assign w_acc0   = req0_valid & req0_ready;
  assign w_acc1   = req1_valid & req1_ready;
  assign w_accept = w_acc0 | w_acc1;

  // Capture strobes: the closing edge of EXEC for the current owner.
  assign w_cap0 = w_exec & ~r_owner;
  assign w_cap1 = w_exec & r_owner;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> EXEC -> DONE -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_nxt = StExec;
        end
      end
      StExec: begin
        w_state_nxt = StDone;
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // Latch the granted operation, its owner and the owner's carry at the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= 1'b0;
      r_op    <= 4'h0;
      r_a     <= 8'h00;
      r_b     <= 8'h00;
      r_cin   <= 1'b0;
    end else if (w_acc0) begin
      r_owner <= 1'b0;
      r_op    <= req0_op;
      r_a     <= req0_a;
      r_b     <= req0_b;
      r_cin   <= CARRY_CTX ? r_carry0 : 1'b0;
    end else if (w_acc1) begin
      r_owner <= 1'b1;
      r_op    <= req1_op;
      r_a     <= req1_a;
      r_b     <= req1_b;
      r_cin   <= CARRY_CTX ? r_carry1 : 1'b0;
    end
  end

  // Round-robin pointer advances when the response is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_done) begin
      r_last_grant <= r_owner;
    end
  end

  // Requester 0 response registers; untouched by requester 1 traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_data  <= 8'h00;
      r_rsp0_flags <= 4'h0;
    end else if (w_cap0) begin
      r_rsp0_data  <= alu_out;
      r_rsp0_flags <= alu_flags;
    end
  end

  // Requester 1 response registers; untouched by requester 0 traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp1_data  <= 8'h00;
      r_rsp1_flags <= 4'h0;
    end else if (w_cap1) begin
      r_rsp1_data  <= alu_out;
      r_rsp1_flags <= alu_flags;
    end
  end

  // Requester 0 carry context; a clear beats a coincident capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry0 <= 1'b0;
    end else if (req0_carry_clr) begin
      r_carry0 <= 1'b0;
    end else if (CARRY_CTX && w_cap0) begin
      r_carry0 <= alu_flags[CoutBit];
    end
  end

  // Requester 1 carry context; a clear beats a coincident capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry1 <= 1'b0;
    end else if (req1_carry_clr) begin
      r_carry1 <= 1'b0;
    end else if (CARRY_CTX && w_cap1) begin
      r_carry1 <= alu_flags[CoutBit];
    end
  end

  // ALU drive: registered operation during EXEC, quiet idle values otherwise.
  always_comb begin
    alu_s_af = 4'h0;
    alu_a    = 8'h00;
    alu_b    = 8'h00;
    alu_cin  = 1'b0;
    if (w_exec) begin
      alu_s_af = r_op;
      alu_a    = r_a;
      alu_b    = r_b;
      alu_cin  = r_cin;
    end
  end

  // Response strobe lasts exactly the DONE cycle, routed to the owner only.
  always_comb begin
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if (w_done) begin
      rsp0_valid = ~r_owner;
      rsp1_valid = r_owner;
    end
  end

  assign rsp0_data  = r_rsp0_data;
  assign rsp0_flags = r_rsp0_flags;
  assign rsp1_data  = r_rsp1_data;
  assign rsp1_flags = r_rsp1_flags;

  assign carry0 = r_carry0;
  assign carry1 = r_carry1;
  assign busy   = w_exec | w_done;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU attached to the ALU port.
module tb_alu_share_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_op, req1_op;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic       req0_carry_clr, req1_carry_clr;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data;
  logic [3:0] rsp0_flags, rsp1_flags;
  logic       carry0, carry1, busy;
  logic [3:0] alu_s_af;
  logic [7:0] alu_a, alu_b;
  logic       alu_cin;
  logic [7:0] alu_out;
  logic [3:0] alu_flags;

  int n_checks;
  int n_errors;

  alu_share_ctrl #(.CARRY_CTX(1'b1)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req0_valid     (req0_valid),
    .req0_ready     (req0_ready),
    .req0_op        (req0_op),
    .req0_a         (req0_a),
    .req0_b         (req0_b),
    .req0_carry_clr (req0_carry_clr),
    .req1_valid     (req1_valid),
    .req1_ready     (req1_ready),
    .req1_op        (req1_op),
    .req1_a         (req1_a),
    .req1_b         (req1_b),
    .req1_carry_clr (req1_carry_clr),
    .rsp0_valid     (rsp0_valid),
    .rsp0_data      (rsp0_data),
    .rsp0_flags     (rsp0_flags),
    .rsp1_valid     (rsp1_valid),
    .rsp1_data      (rsp1_data),
    .rsp1_flags     (rsp1_flags),
    .carry0         (carry0),
    .carry1         (carry1),
    .busy           (busy),
    .alu_s_af       (alu_s_af),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_cin        (alu_cin),
    .alu_out        (alu_out),
    .alu_flags      (alu_flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: flags = {OddParity, Positive, Cout, Zero}.
  logic [8:0] alu_wide;
  always_comb begin
    alu_wide = 9'h000;
    case (alu_s_af)
      4'h1: alu_wide = {1'b0, alu_b};
      4'h2: alu_wide = {1'b0, alu_a & alu_b};
      4'h3: alu_wide = {1'b0, alu_a | alu_b};
      4'h4: alu_wide = {1'b0, alu_a ^ alu_b};
      4'h5: alu_wide = {1'b0, ~alu_a};
      4'h6: alu_wide = {alu_a, alu_cin};
      4'h7: alu_wide = {alu_a[0], alu_cin, alu_a[7:1]};
      4'h8: alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
      4'h9: alu_wide = {1'b0, alu_b} - {1'b0, alu_a};
      4'hA: alu_wide = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
      4'hB: alu_wide = {1'b0, alu_b} - {1'b0, alu_a} - {8'h00, alu_cin};
      default: alu_wide = {1'b0, alu_a};
    endcase
    alu_out   = alu_wide[7:0];
    alu_flags = {^alu_wide[7:0], ~alu_wide[7], alu_wide[8], alu_wide[7:0] == 8'h00};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait for its grant, and return in the DONE cycle.
  task automatic issue(input bit n, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b);
    int k;
    k = 0;
    if (n == 1'b0) begin
      req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
    end else begin
      req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
    end
    #1;
    while (!(n ? req1_ready : req0_ready) && k < 8) begin
      step();
      k++;
    end
    if (k == 8) check_eq("issue_grant_timeout", 32'd0, 32'd1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
  endtask

  int acc_id[8];
  int acc_cyc[8];
  int n_acc;
  int n_rsp;
  int last_acc;

  initial begin
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_op = 4'h0; req1_op = 4'h0;
    req0_a = 8'h00; req0_b = 8'h00; req1_a = 8'h00; req1_b = 8'h00;
    req0_carry_clr = 1'b0; req1_carry_clr = 1'b0;

    // Reset state
    #12;
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp0_valid", rsp0_valid, 0);
    check_eq("rst_rsp1_data", rsp1_data, 0);
    check_eq("rst_carry0", carry0, 0);
    check_eq("rst_alu_s_af", alu_s_af, 0);
    step();
    rst_n = 1'b1;

    // 1. Single req0 ADD_AB 5+3
    req0_valid = 1'b1; req0_op = 4'h8; req0_a = 8'h05; req0_b = 8'h03;
    #1;
    check_eq("t1_ready0", req0_ready, 1);
    check_eq("t1_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    check_eq("t1_exec_op", alu_s_af, 4'h8);
    check_eq("t1_exec_a", alu_a, 8'h05);
    check_eq("t1_exec_busy", busy, 1);
    check_eq("t1_exec_rsp0_valid", rsp0_valid, 0);
    step();
    check_eq("t1_rsp0_valid", rsp0_valid, 1);
    check_eq("t1_rsp1_valid", rsp1_valid, 0);
    check_eq("t1_rsp0_data", rsp0_data, 8'h08);
    check_eq("t1_rsp0_flags", rsp0_flags, 4'b1100);
    check_eq("t1_carry0", carry0, 0);
    step();
    check_eq("t1_pulse_end", rsp0_valid, 0);
    check_eq("t1_idle_alu", alu_s_af, 0);

    // 2. Round-robin from reset with both valid
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_op = 4'h2; req0_a = 8'hF0; req0_b = 8'h3C;
    req1_valid = 1'b1; req1_op = 4'h3; req1_a = 8'hF0; req1_b = 8'h0F;
    n_acc = 0; n_rsp = 0; last_acc = -1;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (rsp0_valid) begin
        n_rsp++;
        check_eq("t2_rsp0_owner", last_acc, 0);
        check_eq("t2_rsp0_data", rsp0_data, 8'h30);
      end
      if (rsp1_valid) begin
        n_rsp++;
        check_eq("t2_rsp1_owner", last_acc, 1);
        check_eq("t2_rsp1_data", rsp1_data, 8'hFF);
      end
      if ((req0_ready || req1_ready) && n_acc < 8) begin
        acc_id[n_acc] = req1_ready ? 1 : 0;
        acc_cyc[n_acc] = c;
        last_acc = acc_id[n_acc];
        n_acc++;
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check_eq("t2_n_acc", n_acc, 4);
    check_eq("t2_n_rsp", n_rsp, 4);
    for (int i = 0; i < 4 && i < n_acc; i++) begin
      check_eq("t2_order", acc_id[i], i % 2);
      if (i > 0) check_eq("t2_spacing", acc_cyc[i] - acc_cyc[i-1], 3);
    end
    step();

    // 3. Carry chaining on req1
    issue(1'b1, 4'h8, 8'hFF, 8'h01);
    check_eq("t3a_rsp1_valid", rsp1_valid, 1);
    check_eq("t3a_rsp1_data", rsp1_data, 8'h00);
    check_eq("t3a_rsp1_flags", rsp1_flags, 4'b0111);
    check_eq("t3a_carry1", carry1, 1);
    check_eq("t3a_carry0", carry0, 0);
    check_eq("t3a_rsp0_held", rsp0_data, 8'h30);
    step();
    issue(1'b1, 4'hA, 8'h00, 8'h00);
    check_eq("t3b_rsp1_data", rsp1_data, 8'h01);
    check_eq("t3b_rsp1_flags", rsp1_flags, 4'b1100);
    check_eq("t3b_carry1", carry1, 0);
    check_eq("t3b_carry0", carry0, 0);
    step();

    // 4. Borrow on req0
    issue(1'b0, 4'h9, 8'h01, 8'h00);
    check_eq("t4_rsp0_data", rsp0_data, 8'hFF);
    check_eq("t4_rsp0_flags", rsp0_flags, 4'b0010);
    check_eq("t4_carry0", carry0, 1);
    check_eq("t4_rsp1_held", rsp1_data, 8'h01);
    step();

    // 5. Reset during EXEC with carry0 = 1
    req0_valid = 1'b1; req0_op = 4'h8; req0_a = 8'h01; req0_b = 8'h01;
    step();
    req0_valid = 1'b0;
    check_eq("t5_exec_cin", alu_cin, 1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_carry0", carry0, 0);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_alu_s_af", alu_s_af, 0);
    check_eq("t5_alu_a", alu_a, 0);
    check_eq("t5_alu_cin", alu_cin, 0);
    check_eq("t5_rsp0_valid", rsp0_valid, 0);
    step();
    rst_n = 1'b1;
    check_eq("t5_no_rsp", rsp0_valid, 0);
    req0_valid = 1'b1;
    #1;
    check_eq("t5_ready_after_rel", req0_ready, 1);
    step();
    req0_valid = 1'b0;
    check_eq("t5_busy_after_acc", busy, 1);
    step();
    check_eq("t5_rsp0_valid_new", rsp0_valid, 1);
    check_eq("t5_rsp0_data_new", rsp0_data, 8'h02);
    step();

    // 6. Carry clear coinciding with a Cout=1 capture
    req0_valid = 1'b1; req0_op = 4'h8; req0_a = 8'hFF; req0_b = 8'hFF;
    step();
    req0_valid = 1'b0;
    req0_carry_clr = 1'b1;
    step();
    req0_carry_clr = 1'b0;
    check_eq("t6_rsp0_valid", rsp0_valid, 1);
    check_eq("t6_rsp0_flags", rsp0_flags, 4'b1010);
    check_eq("t6_carry0", carry0, 0);
    step();

    // Clears are per-requester
    issue(1'b1, 4'h8, 8'h80, 8'h80);
    check_eq("t7_carry1_set", carry1, 1);
    step();
    req0_carry_clr = 1'b1;
    step();
    req0_carry_clr = 1'b0;
    check_eq("t7_carry1_indep", carry1, 1);
    req1_carry_clr = 1'b1;
    step();
    req1_carry_clr = 1'b0;
    check_eq("t7_carry1_clr", carry1, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
